// File: rtl/hazard_if.sv
// hazard_if
// Bundles every pipeline-facing signal of the hazard controller.
//   master : pipeline datapath. It drives register ids, stage flags, MDU
//            requests and memory not-ready, and it receives stall, flush and
//            forward controls.
//   slave  : hazard_ctrl, which has the opposite directions.
// Handshake semantics: the block has no valid/ready pairs. ireq_stall and
// dreq_stall are level "not ready" indications that are sampled every cycle.
// Each Stall* output holds its stage register for the cycle in which it is
// high. MduStartE counts as accepted on a rising edge where MduStartE=1 and
// StallE=0.
// mdu_state_dbg shows the MDU FSM state: 0 idle, 1 busy, 2 done.
interface hazard_if;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD;
  logic       MduStartE, MduDivE, MduUseD;
  logic       ireq_stall, dreq_stall;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       MduBusy, MduDone;
  logic [1:0] mdu_state_dbg;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
           MduStartE, MduDivE, MduUseD, ireq_stall, dreq_stall,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, MduBusy, MduDone,
           mdu_state_dbg
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
           MduStartE, MduDivE, MduUseD, ireq_stall, dreq_stall,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, MduBusy, MduDone,
           mdu_state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and sequencing controller for a 5-stage MIPS pipeline. It produces
// stall and flush controls for the F/D/E/M/W registers, the E- and D-stage
// forwarding selects, and a cycle-counted mult/div busy FSM.
// Ports:
//   clk           clock; all state changes on posedge
//   resetn        synchronous reset, active-low
//   hz            hazard_if.slave (all pipeline-facing signals)
//   stall_cycles  32-bit saturating count of cycles with StallF=1. This port
//                 exists only when HAZARD_PERF_CNT_EN is defined.
// Build option: HAZARD_PERF_CNT_EN. It adds the stall_cycles counter and port.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        resetn,
  hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] lat_load;

  logic lwstall, brstall, mdustall_d, mdustall_e;
  logic stall_f, stall_d, stall_e, stall_m;

  function automatic logic reg_match(input logic [4:0] x, input logic [4:0] r);
    return (x != 5'd0) && (x == r);
  endfunction

  // Hazard detection and the stall chain. A stall in a later stage holds
  // every earlier stage, so the pipeline never splits apart.
  always_comb begin
    lwstall    = hz.MemtoRegE & (reg_match(hz.RtE, hz.RsD) | reg_match(hz.RtE, hz.RtD));
    brstall    = hz.BranchD &
                 ((hz.RegWriteE & (reg_match(hz.WriteRegE, hz.RsD) |
                                   reg_match(hz.WriteRegE, hz.RtD))) |
                  (hz.MemtoRegM & (reg_match(hz.WriteRegM, hz.RsD) |
                                   reg_match(hz.WriteRegM, hz.RtD))));
    mdustall_d = hz.MduUseD & busy_q;
    mdustall_e = hz.MduStartE & busy_q;
    stall_m    = hz.dreq_stall;
    stall_e    = stall_m | mdustall_e;
    stall_d    = stall_e | lwstall | brstall | mdustall_d;
    stall_f    = stall_d | hz.ireq_stall;
  end

  // Output stage. While resetn is low, every register gets a bubble and
  // forwarding is disabled.
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b1;
    hz.FlushE    = 1'b1;
    hz.FlushM    = 1'b1;
    hz.FlushW    = 1'b1;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.ForwardAD = 1'b0;
    hz.ForwardBD = 1'b0;
    hz.MduBusy   = 1'b0;
    hz.MduDone   = 1'b0;
    if (resetn) begin
      hz.StallF = stall_f;
      hz.StallD = stall_d;
      hz.StallE = stall_e;
      hz.StallM = stall_m;
      hz.FlushD = hz.ireq_stall & ~stall_d;
      hz.FlushE = (lwstall | brstall | mdustall_d) & ~stall_e;
      hz.FlushM = mdustall_e & ~stall_m;
      hz.FlushW = stall_m;
      // M has the newer value, so it takes priority over W.
      if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.RsE))      hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.RsE)) hz.ForwardAE = 2'b01;
      if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.RtE))      hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.RtE)) hz.ForwardBE = 2'b01;
      hz.ForwardAD = hz.RegWriteM & reg_match(hz.WriteRegM, hz.RsD);
      hz.ForwardBD = hz.RegWriteM & reg_match(hz.WriteRegM, hz.RtD);
      hz.MduBusy   = busy_q;
      hz.MduDone   = done_q;
    end
  end

  assign hz.mdu_state_dbg = state_q;

  // MDU next state. The counter loads LAT-1. BUSY moves to DONE in the cycle
  // where the decremented count reaches zero, so BUSY plus DONE together
  // take exactly LAT cycles. A LAT of 1 goes straight to DONE. The count
  // freezes while dmem is not ready.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_load = hz.MduDivE ? DIV_LOAD : MUL_LOAD;
    case (state_q)
      MDU_IDLE: begin
        if (hz.MduStartE && !stall_e) begin
          cnt_d   = lat_load;
          state_d = (lat_load == '0) ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        if (!hz.dreq_stall) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = MDU_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != MDU_IDLE);
      done_q  <= (state_d == MDU_DONE);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) stall_cnt_q <= 32'd0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
